adat_frame_buffer: RTL and testbench

Frame buffer and lock qualifier placed directly downstream of the ADAT decoder. It captures each decoded 8-channel, 24-bit frame on the decoder's frame strobe. It qualifies the stream with a lock state machine and holds up to DEPTH frames. It then streams the samples to the mixer core one channel per beat over a valid/ready handshake.

---
 rtl/adat_frame_buffer_if.sv | 27 ++
 rtl/adat_frame_buffer.sv | 197 +++++++++++++++++++
 tb/tb_adat_frame_buffer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adat_frame_buffer_if.sv
// rtl/adat_frame_buffer_if.sv - decoder-side frame inputs and mixer-side sample stream of the ADAT frame buffer
interface adat_frame_buffer_if;
    logic                   in_valid;
    logic                   in_strobe;
    logic [2:0]             in_user;
    logic [7:0][23:0]       in_audio;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [23:0]     out_data;
    logic [2:0]             out_chan;
    logic                   out_last;
    logic [2:0]             out_user;
    logic                   locked;
    logic [15:0]            drop_count;

    // Decoder and mixer side: drives frames and the ready flag
    modport master (
        output in_valid, in_strobe, in_user, in_audio, out_ready,
        input  out_valid, out_data, out_chan, out_last, out_user, locked, drop_count
    );

    // Frame buffer side
    modport slave (
        input  in_valid, in_strobe, in_user, in_audio, out_ready,
        output out_valid, out_data, out_chan, out_last, out_user, locked, drop_count
    );
endinterface

// File: rtl/adat_frame_buffer.sv
// rtl/adat_frame_buffer.sv - ADAT frame capture, lock qualification and per-channel readout (optional macro ADAT_FRAME_BUFFER_STATS_EN)
module adat_frame_buffer #(
    parameter int DEPTH          = 4,
    parameter int LOCK_FRAMES    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    adat_frame_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]    LOCK_N  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {S_UNLOCKED, S_ACQUIRE, S_LOCKED} lock_state_t;

    lock_state_t        r_state;
    lock_state_t        w_state_n;
    logic [7:0]         r_good_cnt;
    logic [7:0]         w_good_cnt_n;
    logic               w_flush;

    logic               r_strobe_d;
    logic [TW-1:0]      r_to_cnt;

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [2:0]         r_chan;
    logic               r_out_valid;
    logic signed [23:0] r_out_data;
    logic [2:0]         r_out_user;

    logic [7:0][23:0]   r_mem_audio [DEPTH];
    logic [2:0]         r_mem_user  [DEPTH];

    logic               w_event;
    logic               w_good;
    logic               w_bad;
    logic               w_timeout;
    logic               w_fire;
    logic               w_pop;
    logic               w_full;
    logic               w_write;
    logic               w_load;
    logic               w_avail;
    logic [2:0]         w_chan_n;
    logic [PW-1:0]      w_rd_n;

    assign w_event   = bus.in_strobe & ~r_strobe_d;
    assign w_good    = w_event & bus.in_valid;
    assign w_bad     = w_event & ~bus.in_valid;
    // Fires only on the cycle the timer steps onto its saturation value
    assign w_timeout = ~w_event & (r_to_cnt == TO_LAST);

    assign w_fire    = r_out_valid & bus.out_ready;
    assign w_pop     = w_fire & (r_chan == 3'd7);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the head slot, so a full buffer still accepts the frame
    assign w_write   = w_good & (r_state == S_LOCKED) & (~w_full | w_pop);

    assign w_chan_n  = w_fire ? r_chan + 3'd1 : r_chan;
    assign w_rd_n    = r_rd_ptr + PW'(w_pop);
    assign w_load    = ~r_out_valid | w_fire;
    assign w_avail   = (w_rd_n != r_wr_ptr);

    // Strobe history for edge detection and the strobe-gap timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_strobe_d <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_strobe_d <= bus.in_strobe;
            if (w_event) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_SAT) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    // Lock state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_UNLOCKED;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_good_cnt <= w_good_cnt_n;
        end
    end

    // Lock next-state: count consecutive good frames, drop on a bad frame or strobe timeout
    always_comb begin
        w_state_n    = r_state;
        w_good_cnt_n = r_good_cnt;
        w_flush      = 1'b0;
        case (r_state)
            S_UNLOCKED: begin
                if (w_good) begin
                    w_good_cnt_n = 8'd1;
                    w_state_n    = (LOCK_N == 8'd1) ? S_LOCKED : S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                if (w_bad || w_timeout) begin
                    w_state_n    = S_UNLOCKED;
                    w_good_cnt_n = '0;
                end else if (w_good) begin
                    w_good_cnt_n = r_good_cnt + 8'd1;
                    if (w_good_cnt_n == LOCK_N) begin
                        w_state_n = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (w_bad || w_timeout) begin
                    w_state_n    = S_UNLOCKED;
                    w_good_cnt_n = '0;
                    w_flush      = 1'b1;
                end
            end
            default: begin
                w_state_n    = S_UNLOCKED;
                w_good_cnt_n = '0;
            end
        endcase
    end

    // Frame storage; contents need no reset since the pointers gate every read
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_audio[r_wr_ptr[AW-1:0]] <= bus.in_audio;
            r_mem_user[r_wr_ptr[AW-1:0]]  <= bus.in_user;
        end
    end

    // Pointers and output register: refill whenever the current beat is taken or none is shown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_chan      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_user  <= '0;
        end else if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_chan      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_rd_ptr <= w_rd_n;
            r_chan   <= w_chan_n;
            if (w_load) begin
                r_out_valid <= w_avail;
                if (w_avail) begin
                    r_out_data <= $signed(r_mem_audio[w_rd_n[AW-1:0]][w_chan_n]);
                    r_out_user <= r_mem_user[w_rd_n[AW-1:0]];
                end
            end
        end
    end

`ifdef ADAT_FRAME_BUFFER_STATS_EN
    logic        w_drop;
    logic [15:0] r_drop_count;

    assign w_drop = w_good & (r_state == S_LOCKED) & w_full & ~w_pop;

    // Saturating count of locked frames lost to a full buffer; survives lock loss
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign bus.drop_count = r_drop_count;
`else
    assign bus.drop_count = 16'h0000;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_chan;
    assign bus.out_last  = (r_chan == 3'd7);
    assign bus.out_user  = r_out_user;
    assign bus.locked    = (r_state == S_LOCKED);
endmodule

// File: tb/tb_adat_frame_buffer.sv
// tb/tb_adat_frame_buffer.sv - scoreboard bench for adat_frame_buffer
module tb_adat_frame_buffer;
`ifdef ADAT_FRAME_BUFFER_STATS_EN
    localparam int EXP_DROP = 2;
`else
    localparam int EXP_DROP = 0;
`endif

    typedef struct {
        logic [23:0] data;
        logic [2:0]  chan;
        logic [2:0]  user;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   ready_mode;
    beat_t exp_q[$];

    adat_frame_buffer_if bus ();

    adat_frame_buffer dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] mk(input logic [7:0] id, input int c);
        return {id, 1'b0, 3'(c), 12'h5A3};
    endfunction

    task automatic raise_frame(input logic good, input logic [7:0] id, input logic store);
        for (int c = 0; c < 8; c++) bus.in_audio[c] = mk(id, c);
        bus.in_user  = id[2:0];
        bus.in_valid = good;
        if (store) begin
            for (int c = 0; c < 8; c++) exp_q.push_back('{data: mk(id, c), chan: 3'(c), user: id[2:0]});
        end
        bus.in_strobe = 1'b1;
    endtask

    task automatic release_frame(input int hold, input int gap);
        repeat (hold) begin @(posedge clk); #2; end
        bus.in_strobe = 1'b0;
        bus.in_valid  = 1'b0;
        repeat (gap) begin @(posedge clk); #2; end
    endtask

    task automatic send(input logic good, input logic [7:0] id, input logic store, input int gap);
        raise_frame(good, id, store);
        release_frame(3, gap);
    endtask

    // 16 good unstored frames; locked must rise exactly in the cycle after the 16th event
    task automatic relock(input int gap);
        for (int i = 0; i < 15; i++) send(1'b1, 8'h40 + 8'(i), 1'b0, gap);
        chk("lock_before_16th", {31'd0, bus.locked}, 32'd0);
        raise_frame(1'b1, 8'h4F, 1'b0);
        @(negedge clk);
        chk("lock_event_cycle", {31'd0, bus.locked}, 32'd0);
        @(negedge clk);
        chk("lock_next_cycle", {31'd0, bus.locked}, 32'd1);
        release_frame(2, gap);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    // out_ready driver: 0 = stalled, 1 = always ready, otherwise random
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability
    initial begin
        logic        prev_stall;
        logic [23:0] prev_data;
        logic [2:0]  prev_chan;
        logic [2:0]  prev_user;
        beat_t       b;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_chan  = '0;
        prev_user  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && bus.out_valid) begin
                    chk("stall_data", {8'd0, bus.out_data}, {8'd0, prev_data});
                    chk("stall_chan", {29'd0, bus.out_chan}, {29'd0, prev_chan});
                    chk("stall_user", {29'd0, bus.out_user}, {29'd0, prev_user});
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {29'd0, bus.out_chan}, 32'hFFFF_FFFF);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", {8'd0, bus.out_data}, {8'd0, b.data});
                        chk("beat_chan", {29'd0, bus.out_chan}, {29'd0, b.chan});
                        chk("beat_user", {29'd0, bus.out_user}, {29'd0, b.user});
                        chk("beat_last", {31'd0, bus.out_last}, {31'd0, (b.chan == 3'd7)});
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_chan  = bus.out_chan;
                prev_user  = bus.out_user;
            end
        end
    end

    initial begin
        int n;
        n_cmp         = 0;
        n_bad         = 0;
        ready_mode    = 1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_strobe = 1'b0;
        bus.in_user   = '0;
        bus.in_audio  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", {8'd0, bus.out_data}, 32'd0);
        chk("rst_chan", {29'd0, bus.out_chan}, 32'd0);
        chk("rst_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst_user", {29'd0, bus.out_user}, 32'd0);
        chk("rst_locked", {31'd0, bus.locked}, 32'd0);
        chk("rst_drop", {16'd0, bus.drop_count}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #2; end

        // Lock acquisition at 2048-clock spacing, then first stored frame and its latency
        relock(2048);
        raise_frame(1'b1, 8'h91, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("latency_n1_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_n2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("latency_n2_chan", {29'd0, bus.out_chan}, 32'd0);
        release_frame(1, 20);
        drain("drain_first");

        // Bad frame while locked with two frames buffered
        ready_mode = 0;
        send(1'b1, 8'h12, 1'b1, 10);
        send(1'b1, 8'h13, 1'b1, 10);
        chk("stalled_valid", {31'd0, bus.out_valid}, 32'd1);
        exp_q.delete();
        raise_frame(1'b0, 8'h14, 1'b0);
        @(negedge clk);
        chk("bad_event_locked", {31'd0, bus.locked}, 32'd1);
        @(negedge clk);
        chk("bad_next_locked", {31'd0, bus.locked}, 32'd0);
        chk("bad_next_valid", {31'd0, bus.out_valid}, 32'd0);
        release_frame(2, 10);
        ready_mode = 1;
        relock(40);
        send(1'b1, 8'h20, 1'b1, 20);
        drain("drain_after_relock");

        // Strobe timeout while locked
        ready_mode = 0;
        raise_frame(1'b1, 8'h30, 1'b1);
        @(posedge clk);
        n = 0;
        while (n < 6000) begin
            @(posedge clk);
            n++;
            if (n == 3) begin #2; bus.in_strobe = 1'b0; end
            @(negedge clk);
            if (!bus.locked) break;
        end
        chk("timeout_cycles", n, 32'd4096);
        chk("timeout_valid", {31'd0, bus.out_valid}, 32'd0);
        exp_q.delete();
        @(posedge clk); #2;

        // Overflow: six frames into a four-deep buffer with the consumer stalled
        relock(40);
        for (int i = 0; i < 6; i++) send(1'b1, 8'hA1 + 8'(i), (i < 4), 10);
        chk("overflow_drop", {16'd0, bus.drop_count}, EXP_DROP);
        ready_mode = 1;
        drain("drain_overflow");

        // Chan-7 pop of the head coincides with a frame event while full
        ready_mode = 0;
        for (int i = 0; i < 4; i++) send(1'b1, 8'h51 + 8'(i), 1'b1, 10);
        chk("full_drop_pre", {16'd0, bus.drop_count}, EXP_DROP);
        ready_mode = 1;
        repeat (8) @(posedge clk);
        #2;
        chk("coinc_chan7", {27'd0, bus.out_ready, bus.out_valid, bus.out_chan}, 32'h1F);
        raise_frame(1'b1, 8'h55, 1'b1);
        release_frame(3, 10);
        drain("drain_coinc");
        chk("coinc_drop", {16'd0, bus.drop_count}, EXP_DROP);

        // Random backpressure
        ready_mode = 2;
        for (int i = 0; i < 5; i++) send(1'b1, 8'hE1 + 8'(i), 1'b1, 30);
        drain("drain_random");
        ready_mode = 1;

        // Reset asserted with frames in flight
        ready_mode = 0;
        send(1'b1, 8'h71, 1'b1, 5);
        send(1'b1, 8'h72, 1'b1, 5);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_locked", {31'd0, bus.locked}, 32'd0);
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_chan", {29'd0, bus.out_chan}, 32'd0);
        chk("midrst_drop", {16'd0, bus.drop_count}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ready_mode = 1;
        relock(20);
        send(1'b1, 8'h81, 1'b1, 20);
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
